// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Accepts one parallel byte per request and
// serializes it as start bit (0), data LSB first, optional parity, stop bit (1).
// Bit timing comes from a per-frame prescale count latched at acceptance.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   RST        synchronous active-low reset
//   P_DATA     parallel data to send
//   Data_Valid request strobe; P_DATA and config are sampled with it
//   PAR_EN     1 = append parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   Prescale   clk cycles per bit; 0 is treated as 1
//   TX_OUT     registered serial line, idles high
//   busy       registered, high while a frame is in progress
//
// Optional feature: define UART_TX_STOP2_EN for two stop bits (STOP lasts 2*N).
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bit_q;
  logic                  par_en_q;
  logic [PRESCALE_W-1:0] presc_q;
  // One extra bit so a double-length stop bit fits in the same counter.
  logic [PRESCALE_W:0]   cnt_q;
  logic [IdxW-1:0]       bit_idx_q;

  logic [PRESCALE_W:0]   bit_end;
  logic [PRESCALE_W:0]   stop_end;
  logic                  cnt_last;
  logic [DATA_WIDTH-1:0] shift_nxt;

  always_comb begin
    bit_end = {1'b0, presc_q} - (PRESCALE_W + 1)'(1);
`ifdef UART_TX_STOP2_EN
    stop_end = {presc_q, 1'b0} - (PRESCALE_W + 1)'(1);
`else
    stop_end = bit_end;
`endif
    cnt_last  = (state_q == StStop) ? (cnt_q == stop_end) : (cnt_q == bit_end);
    shift_nxt = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else if (state_q == StIdle) begin
      if (Data_Valid) begin
        shift_q   <= P_DATA;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        par_en_q  <= PAR_EN;
        presc_q   <= (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
        cnt_q     <= '0;
        bit_idx_q <= '0;
        state_q   <= StStart;
        TX_OUT    <= 1'b0;
        busy      <= 1'b1;
      end
    end else if (!cnt_last) begin
      cnt_q <= cnt_q + (PRESCALE_W + 1)'(1);
    end else begin
      // End of the current bit: TX_OUT is loaded with the next bit's value.
      cnt_q <= '0;
      case (state_q)
        StStart: begin
          state_q <= StData;
          TX_OUT  <= shift_q[0];
        end
        StData: begin
          if (bit_idx_q == LastIdx) begin
            if (par_en_q) begin
              state_q <= StParity;
              TX_OUT  <= par_bit_q;
            end else begin
              state_q <= StStop;
              TX_OUT  <= 1'b1;
            end
          end else begin
            bit_idx_q <= bit_idx_q + IdxW'(1);
            shift_q   <= shift_nxt;
            TX_OUT    <= shift_nxt[0];
          end
        end
        StParity: begin
          state_q <= StStop;
          TX_OUT  <= 1'b1;
        end
        StStop: begin
          state_q <= StIdle;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed self-checking bench for uart_tx_frame.
// Expected line values are built from the frame format for each request.
module tb_uart_tx_frame;

  logic       clk;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_frame #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk({tag, "_tx"}, TX_OUT, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      step();
    end
  endtask

  // Issue a request, then check every cycle of the frame and the idle cycle
  // after it. pulse_at: frame cycle at which a competing request is pulsed.
  // abort_at: frame cycle at which RST is asserted for one edge.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic pt, input int ps, input bit hold,
                           input int pulse_at, input int abort_at);
    logic exp_bits [0:12];
    int   nb;
    int   n;
    int   busy_cnt;
    n  = (ps == 0) ? 1 : ps;
    nb = 0;
    exp_bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[nb++] = d[i];
    if (pe) exp_bits[nb++] = (^d) ^ pt;
    exp_bits[nb++] = 1'b1;
`ifdef UART_TX_STOP2_EN
    exp_bits[nb++] = 1'b1;
`endif
    busy_cnt   = 0;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = 6'(ps);
    Data_Valid = 1'b1;
    step();
    if (!hold) Data_Valid = 1'b0;
    for (int i = 0; i < nb * n; i++) begin
      if (i == abort_at) begin
        RST = 1'b0;
        step();
        RST = 1'b1;
        chk({tag, "_abort_tx"}, TX_OUT, 1'b1);
        chk({tag, "_abort_busy"}, busy, 1'b0);
        return;
      end
      if (i == pulse_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h00;
        Prescale   = 6'd1;
        PAR_EN     = 1'b1;
      end
      chk({tag, "_tx"}, TX_OUT, exp_bits[i / n]);
      chk({tag, "_busy"}, busy, 1'b1);
      if (busy === 1'b1) busy_cnt++;
      step();
      if (i == pulse_at) Data_Valid = 1'b0;
    end
    chk({tag, "_gap_tx"}, TX_OUT, 1'b1);
    chk({tag, "_gap_busy"}, busy, 1'b0);
    chk_int({tag, "_busy_len"}, busy_cnt, nb * n);
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd0;
    step();
    step();
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", busy, 1'b0);
    RST = 1'b1;
    chk_idle("idle20", 20);

    // 0xA5 even parity: parity bit 0
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 8, 1'b0, -1, -1);
    step();
    // Odd parity: 0x01 -> parity 0, 0x03 -> parity 1
    run_frame("01_odd", 8'h01, 1'b1, 1'b1, 4, 1'b0, -1, -1);
    step();
    run_frame("03_odd", 8'h03, 1'b1, 1'b1, 4, 1'b0, -1, -1);
    step();

    // Request mid-frame is dropped and input changes do not disturb the frame
    run_frame("ff_drop", 8'hFF, 1'b0, 1'b0, 4, 1'b0, 10, -1);
    chk_idle("after_drop", 12);

    // Held request: back-to-back frames separated by exactly one idle cycle
    run_frame("held0", 8'h55, 1'b0, 1'b0, 2, 1'b1, -1, -1);
    run_frame("held1", 8'h55, 1'b0, 1'b0, 2, 1'b1, -1, -1);
    run_frame("held2", 8'h55, 1'b0, 1'b0, 2, 1'b0, -1, -1);
    chk_idle("after_held", 5);

    // Reset mid-frame aborts; a fresh request then gives a clean frame
    run_frame("3c_abort", 8'h3C, 1'b0, 1'b0, 8, 1'b0, -1, 30);
    chk_idle("post_abort", 5);
    run_frame("3c_clean", 8'h3C, 1'b0, 1'b0, 8, 1'b0, -1, -1);
    step();

    // Prescale 0 behaves as one cycle per bit
    run_frame("presc0", 8'h96, 1'b1, 1'b1, 0, 1'b0, -1, -1);
    chk_idle("final", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
